// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - write-domain pointer, full flag and level for the async FIFO (optional almost_full via WPTR_AFULL_EN)
module fifo_wptr_full #(
    parameter int PTR_SIZE     = 8,
    parameter int AFULL_THRESH = 248
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_en,
    input  logic [PTR_SIZE:0] g_rptr,
    output logic [PTR_SIZE:0] b_wptr,
    output logic [PTR_SIZE:0] g_wptr,
    output logic              full,
    output logic [PTR_SIZE:0] wr_level
`ifdef WPTR_AFULL_EN
    ,
    output logic              almost_full
`endif
);

    if (PTR_SIZE < 2) begin : g_bad_ptr_size
        $error("PTR_SIZE must be at least 2");
    end
    if (AFULL_THRESH > (1 << PTR_SIZE)) begin : g_bad_afull
        $error("AFULL_THRESH exceeds FIFO depth");
    end

    logic [PTR_SIZE:0] rq1_q, rq1_d;
    logic [PTR_SIZE:0] rq2_q, rq2_d;
    logic [PTR_SIZE:0] b_wptr_q, b_wptr_d;
    logic [PTR_SIZE:0] g_wptr_q, g_wptr_d;
    logic [PTR_SIZE:0] wr_level_q, wr_level_d;
    logic              full_q, full_d;

    logic              wr_inc;
    logic [PTR_SIZE:0] b_next;
    logic [PTR_SIZE:0] g_next;
    logic [PTR_SIZE:0] b_rptr_s;

    always_comb begin
        rq1_d  = g_rptr;
        rq2_d  = rq1_q;
        // acceptance uses the registered full, so a write racing a full-clear edge is rejected
        wr_inc = w_en & ~full_q;
        b_next = b_wptr_q + {{PTR_SIZE{1'b0}}, wr_inc};
        g_next = b_next ^ (b_next >> 1);

        b_rptr_s = '0;
        for (int i = 0; i <= PTR_SIZE; i++) begin
            b_rptr_s[i] = ^(rq2_q >> i);
        end

        b_wptr_d   = b_next;
        g_wptr_d   = g_next;
        // full when the write pointer is exactly one lap ahead of the synced read pointer
        full_d     = (g_next == {~rq2_q[PTR_SIZE:PTR_SIZE-1], rq2_q[PTR_SIZE-2:0]});
        wr_level_d = b_next - b_rptr_s;
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            rq1_q      <= '0;
            rq2_q      <= '0;
            b_wptr_q   <= '0;
            g_wptr_q   <= '0;
            wr_level_q <= '0;
            full_q     <= 1'b0;
        end else begin
            rq1_q      <= rq1_d;
            rq2_q      <= rq2_d;
            b_wptr_q   <= b_wptr_d;
            g_wptr_q   <= g_wptr_d;
            wr_level_q <= wr_level_d;
            full_q     <= full_d;
        end
    end

    assign b_wptr   = b_wptr_q;
    assign g_wptr   = g_wptr_q;
    assign full     = full_q;
    assign wr_level = wr_level_q;

`ifdef WPTR_AFULL_EN
    localparam logic [PTR_SIZE:0] AFULL_LVL = AFULL_THRESH[PTR_SIZE:0];

    logic almost_full_q, almost_full_d;

    always_comb begin
        almost_full_d = (wr_level_d >= AFULL_LVL);
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb/tb_fifo_wptr_full.sv - directed and randomized checks of fifo_wptr_full against a counting model
module tb_fifo_wptr_full;
    localparam int P     = 8;
    localparam int DEPTH = 256;
    localparam int MOD   = 512;
    localparam int AF_TH = 248;

    logic         w_clk = 1'b0;
    logic         w_rst;
    logic         w_en;
    logic [P:0]   g_rptr;
    logic [P:0]   b_wptr;
    logic [P:0]   g_wptr;
    logic         full;
    logic [P:0]   wr_level;
`ifdef WPTR_AFULL_EN
    logic         almost_full;
`endif

    fifo_wptr_full #(.PTR_SIZE(P), .AFULL_THRESH(AF_TH)) dut (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .w_en     (w_en),
        .g_rptr   (g_rptr),
        .b_wptr   (b_wptr),
        .g_wptr   (g_wptr),
        .full     (full),
        .wr_level (wr_level)
`ifdef WPTR_AFULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 w_clk = ~w_clk;

    int checks   = 0;
    int failures = 0;

    // model: write count and read count seen two edges late, all as plain integers
    int m_w, m_wtot, m_rq1, m_rq2, m_level;
    bit m_full, m_af;
    int rcount;
    logic [P:0] prev_g;

    function automatic logic [P:0] gray(input int v);
        logic [P:0] b;
        b = v[P:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".b_wptr"}, 32'(b_wptr), m_w);
        check({tag, ".g_wptr"}, 32'(g_wptr), 32'(gray(m_w)));
        check({tag, ".full"}, 32'(full), 32'(m_full));
        check({tag, ".wr_level"}, 32'(wr_level), m_level);
        check({tag, ".gray_step"}, 32'($countones(g_wptr ^ prev_g) <= 1), 1);
`ifdef WPTR_AFULL_EN
        check({tag, ".almost_full"}, 32'(almost_full), 32'(m_af));
`endif
        prev_g = g_wptr;
    endtask

    task automatic step(input bit we, input string tag);
        bit acc;
        @(negedge w_clk);
        w_en   = we;
        g_rptr = gray(rcount % MOD);
        @(posedge w_clk);
        acc     = we && !m_full;
        m_w     = (m_w + int'(acc)) % MOD;
        m_wtot  = m_wtot + int'(acc);
        m_level = (m_w - m_rq2 + MOD) % MOD;
        m_full  = (m_level == DEPTH);
        m_af    = (m_level >= AF_TH);
        m_rq2   = m_rq1;
        m_rq1   = rcount % MOD;
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge w_clk);
        #2;
        w_rst = 1'b1;
        #1;
        check({tag, ".b_wptr"}, 32'(b_wptr), 0);
        check({tag, ".g_wptr"}, 32'(g_wptr), 0);
        check({tag, ".wr_level"}, 32'(wr_level), 0);
        check({tag, ".full"}, 32'(full), 0);
`ifdef WPTR_AFULL_EN
        check({tag, ".almost_full"}, 32'(almost_full), 0);
`endif
        m_w = 0; m_wtot = 0; m_rq1 = 0; m_rq2 = 0; m_level = 0;
        m_full = 0; m_af = 0; rcount = 0; prev_g = '0;
        w_en = 1'b0;
        g_rptr = '0;
        @(negedge w_clk);
        w_rst = 1'b0;
    endtask

    initial begin
        w_rst = 1'b1; w_en = 1'b0; g_rptr = '0;
        m_w = 0; m_wtot = 0; m_rq1 = 0; m_rq2 = 0; m_level = 0;
        m_full = 0; m_af = 0; rcount = 0; prev_g = '0;
        #3;
        check("por.b_wptr", 32'(b_wptr), 0);
        check("por.full", 32'(full), 0);
        @(negedge w_clk);
        w_rst = 1'b0;

        // reset mid-operation
        for (int i = 0; i < 10; i++) step(1'b1, "pre_rst");
        do_reset("mid_rst");

        // fill to full, then one rejected write
        for (int i = 0; i < DEPTH; i++) step(1'b1, "fill");
        check("fill.full_at_256", 32'(full), 1);
        check("fill.level_256", 32'(wr_level), DEPTH);
        step(1'b1, "fill_over");
        check("fill_over.b_wptr", 32'(b_wptr), DEPTH);

        // drain release: full clears on 3rd edge, that write rejected, next accepted
        rcount = 1;
        step(1'b1, "drain1");
        check("drain1.full", 32'(full), 1);
        step(1'b1, "drain2");
        check("drain2.full", 32'(full), 1);
        step(1'b1, "drain3");
        check("drain3.full", 32'(full), 0);
        check("drain3.level", 32'(wr_level), 255);
        check("drain3.b_wptr", 32'(b_wptr), DEPTH);
        step(1'b1, "drain4");
        check("drain4.b_wptr", 32'(b_wptr), 257);

        // wrap-around
        do_reset("wrap_rst");
        for (int i = 0; i < DEPTH; i++) step(1'b1, "wrap_fill");
        rcount = DEPTH;
        for (int i = 0; i < 3; i++) step(1'b0, "wrap_sync");
        check("wrap.level0", 32'(wr_level), 0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, "wrap_fill2");
        check("wrap.b_wptr0", 32'(b_wptr), 0);
        check("wrap.g_wptr0", 32'(g_wptr), 0);
        check("wrap.full", 32'(full), 1);

        // simultaneous read stepping while writing
        for (int i = 0; i < 40; i++) begin
            if (rcount < m_wtot) rcount++;
            step(1'b1, "simul");
            check("simul.level_band", 32'(wr_level == 9'd255 || wr_level == 9'd256), 1);
        end

`ifdef WPTR_AFULL_EN
        do_reset("af_rst");
        for (int i = 0; i < AF_TH - 1; i++) step(1'b1, "af_fill");
        check("af.247", 32'(almost_full), 0);
        step(1'b1, "af_248");
        check("af.248", 32'(almost_full), 1);
        rcount = 1;
        step(1'b0, "af_rd1");
        step(1'b0, "af_rd2");
        check("af.rd2", 32'(almost_full), 1);
        step(1'b0, "af_rd3");
        check("af.rd3", 32'(almost_full), 0);
`endif

        // randomized traffic with shifting read/write bias
        do_reset("rnd_rst");
        for (int i = 0; i < 3000; i++) begin
            int rd_bias;
            rd_bias = ((i / 500) % 2 == 0) ? 3 : 1;
            if ($urandom_range(0, 3) < rd_bias && rcount < m_wtot) rcount++;
            step($urandom_range(0, 3) != 0, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-domain pointer and full-flag generator for the async FIFO.
- Sits directly upstream of fifo_memory: drives its b_wptr address and full input.
- Synchronizes the read-domain Gray pointer into w_clk and keeps binary and Gray write pointers.
- Produces a registered full flag and a conservative write-side occupancy count.

Parameters:
- PTR_SIZE, 8, address bits; DEPTH = 2**PTR_SIZE (256); pointers are PTR_SIZE+1 bits; legal PTR_SIZE >= 2.
- AFULL_THRESH, 248, almost-full level; only used when WPTR_AFULL_EN is defined.

Ports:
- w_clk  input  1  write-domain clock.
- w_rst  input  1  reset, asynchronous, active-high; the block's only reset.
- w_en  input  1  write request; same signal fifo_memory sees.
- g_rptr  input  PTR_SIZE+1  Gray read pointer, driven from r_clk domain, unsynchronized.
- b_wptr  output  PTR_SIZE+1  binary write pointer, registered; low PTR_SIZE bits are the memory address.
- g_wptr  output  PTR_SIZE+1  Gray write pointer, registered; goes to read-domain synchronizer.
- full  output  1  FIFO full, registered.
- wr_level  output  PTR_SIZE+1  occupancy seen from write side, registered, range 0..DEPTH.
- almost_full  output  1  present only with WPTR_AFULL_EN.

Behaviour:
- Reset (async assert, release synchronous to w_clk): b_wptr, g_wptr, wr_level, both sync flops, full and almost_full all go to 0 immediately.
- Read pointer sync: two flops, g_rptr -> rq1 -> rq2. rq2 is Gray-to-binary converted combinationally (prefix XOR from MSB) to b_rptr_s.
- Write accept: wr_inc = w_en & ~full, using the current registered full.
  - b_next = b_wptr + wr_inc, modulo 2^(PTR_SIZE+1).
  - g_next = b_next ^ (b_next >> 1).
  - Both pointers load on every w_clk edge.
- Full: full <= (g_next == {~rq2[PTR_SIZE:PTR_SIZE-1], rq2[PTR_SIZE-2:0]}).
- Level: wr_level <= (b_next - b_rptr_s) mod 2^(PTR_SIZE+1). Never exceeds DEPTH.
- Latency:
  - An accepted write updates b_wptr/g_wptr on the same edge that fifo_memory stores the data at the old b_wptr.
  - full asserts on the edge of the DEPTH-th outstanding write, with no lag.
  - full deasserts on the 3rd w_clk edge after g_rptr changes: 2 sync edges plus 1 register. Pessimistic by design.
- Write while full:
  - Pointers hold and level holds.
  - full is re-evaluated every cycle, so it stays 1 until rq2 moves.
  - fifo_memory flags write_error independently; this block has no error output.
- Simultaneous w_en and full-clearing edge: the write is rejected, because acceptance uses the full value before the edge. It is accepted on the next edge.
- Wrap-around: the MSB toggles every DEPTH writes; both Gray and binary pointers wrap 2^(PTR_SIZE+1) -> 0 with no special casing.
- g_wptr changes at most one bit per edge. Must be a flop output, with no combinational path to the read domain.
- Reset mid-operation: outputs clear asynchronously and any in-flight write is lost. The read domain must also be reset; cross-domain reset sequencing is owned by the top level.

Optional Feature:
- Macro: WPTR_AFULL_EN.
- Defined:
  - almost_full port exists.
  - almost_full <= (level_next >= AFULL_THRESH), where level_next is the same value loaded into wr_level.
  - Same latency as wr_level; reset 0.
- Undefined: almost_full port and AFULL_THRESH logic are absent. The remaining behaviour is identical.

Test Plan:
1. Reset: drive w_en=1 and g_rptr=0 for 10 writes, then assert w_rst between edges -> b_wptr, g_wptr, wr_level and full read 0 before the next w_clk edge.
2. Fill: g_rptr=0 held, 256 back-to-back writes -> b_wptr steps 0..256 with g_wptr=gray(b_wptr); full=1 and wr_level=256 at the 256th edge; a 257th write leaves b_wptr=256.
3. Drain release: from full, set g_rptr=gray(1)=0x001 -> full stays 1 for 2 edges, becomes 0 on the 3rd edge with wr_level=255; a write on that edge is rejected, and the next is accepted (b_wptr=257).
4. Wrap: g_rptr=gray(256)=0x180 synced with b_wptr=256 -> wr_level=0; 256 writes -> b_wptr=0, g_wptr=0x000, full=1.
5. Simultaneous: w_en=1 held while g_rptr steps by one Gray code per cycle -> one write accepted per visible read; level stays at 255/256; no pointer jump greater than 1.
6. Almost-full (WPTR_AFULL_EN, AFULL_THRESH=248): 247 writes -> almost_full=0; 248th write -> almost_full=1 on that edge; one read made visible -> almost_full=0 on the 3rd edge.
